// File: rtl/resize_pkg.sv
// resize_pkg: shared types for the resize_stream frame resizer.
// Mode encodings, FSM states and output-dimension helpers.
package resize_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_BAD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PROC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Output width for a given mode and input width.
  function automatic int unsigned out_w(
    input mode_e       m,
    input int unsigned w
  );
    case (m)
      MODE_UP:   out_w = 2 * w;
      MODE_DOWN: out_w = w / 2;
      default:   out_w = w;
    endcase
  endfunction

  // Output height for a given mode and input height.
  function automatic int unsigned out_h(
    input mode_e       m,
    input int unsigned h
  );
    case (m)
      MODE_UP:   out_h = 2 * h;
      MODE_DOWN: out_h = h / 2;
      default:   out_h = h;
    endcase
  endfunction

endpackage

// File: rtl/resize_fbuf.sv
// resize_fbuf: frame store, one write port, four async read ports.
// Ports: clk, we/waddr/wdata write, raddr_*/rdata_* reads.
module resize_fbuf #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic [AW-1:0]    raddr_d,
  input  logic [AW-1:0]    raddr_e,
  output logic [PIX_W-1:0] rdata_a,
  output logic [PIX_W-1:0] rdata_b,
  output logic [PIX_W-1:0] rdata_d,
  output logic [PIX_W-1:0] rdata_e
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Contents are not reset; a frame always rewrites every word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
  assign rdata_d = mem_q[raddr_d];
  assign rdata_e = mem_q[raddr_e];

endmodule

// File: rtl/resize_stream.sv
// resize_stream: buffers one frame, then streams it pass/2x up/2x down.
// Ports: clk, rst (async low), start/mode, in_* and out_* streams, busy, err.
module resize_stream
  import resize_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 410,
  parameter int IMG_H = 361
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW   = $clog2(2 * MAXD + 1);
  localparam logic [31:0] W32 = 32'(IMG_W);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [AW-1:0]    in_idx_q, in_idx_d;
  logic [CW-1:0]    gen_r_q, gen_r_d;
  logic [CW-1:0]    gen_c_q, gen_c_d;
  logic             gen_done_q, gen_done_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  logic             in_fire;
  logic             out_fire;
  logic             load_en;
  logic [31:0]      ow, oh;
  logic [31:0]      r32, c32;
  logic [31:0]      addr_a32;
  logic [AW-1:0]    ra, rb, rd, re;
  logic [PIX_W-1:0] px_a, px_b, px_d, px_e;
  logic [PIX_W+1:0] sum;
  logic [PIX_W-1:0] pix;
  logic             c_last, r_last;

  resize_fbuf #(
    .PIX_W (PIX_W),
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_fbuf (
    .clk     (clk),
    .we      (in_fire),
    .waddr   (in_idx_q),
    .wdata   (in_data),
    .raddr_a (ra),
    .raddr_b (rb),
    .raddr_d (rd),
    .raddr_e (re),
    .rdata_a (px_a),
    .rdata_b (px_b),
    .rdata_d (px_d),
    .rdata_e (px_e)
  );

  assign ow = out_w(mode_q, IMG_W);
  assign oh = out_h(mode_q, IMG_H);
  assign r32 = 32'(gen_r_q);
  assign c32 = 32'(gen_c_q);
  assign c_last = (c32 == ow - 32'd1);
  assign r_last = (r32 == oh - 32'd1);

  // Port a is the top-left source pixel; b, d, e complete the 2x2 block.
  always_comb begin
    addr_a32 = r32 * W32 + c32;
    case (mode_q)
      MODE_UP:   addr_a32 = (r32 >> 1) * W32 + (c32 >> 1);
      MODE_DOWN: addr_a32 = (r32 << 1) * W32 + (c32 << 1);
      default:   addr_a32 = r32 * W32 + c32;
    endcase
  end

  assign ra = AW'(addr_a32);
  assign rb = AW'(addr_a32 + 32'd1);
  assign rd = AW'(addr_a32 + W32);
  assign re = AW'(addr_a32 + W32 + 32'd1);

  // Sum is PIX_W+2 wide so four max pixels plus rounding never wrap.
  assign sum = {2'b00, px_a} + {2'b00, px_b}
             + {2'b00, px_d} + {2'b00, px_e}
             + (PIX_W+2)'(2);
  assign pix = (mode_q == MODE_DOWN) ? PIX_W'(sum >> 2) : px_a;

  assign in_fire  = (state_q == S_LOAD) && in_valid;
  assign out_fire = out_valid_q && out_ready;
  // Refill the output register when it is empty or draining this cycle.
  assign load_en  = (state_q == S_PROC) && !gen_done_q
                 && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    in_idx_d    = in_idx_q;
    gen_r_d     = gen_r_q;
    gen_c_d     = gen_c_q;
    gen_done_d  = gen_done_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode == MODE_BAD) begin
            err_d = 1'b1;
          end else begin
            mode_d     = mode_e'(mode);
            state_d    = S_LOAD;
            in_idx_d   = '0;
            gen_r_d    = '0;
            gen_c_d    = '0;
            gen_done_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          in_idx_d = in_idx_q + AW'(1);
          if (in_idx_q == AW'(NPIX - 1)) begin
            state_d = S_PROC;
          end
        end
      end
      S_PROC: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
          end
        end
        if (load_en) begin
          out_data_d  = pix;
          out_valid_d = 1'b1;
          out_last_d  = c_last && r_last;
          if (c_last) begin
            gen_c_d = '0;
            if (r_last) begin
              gen_done_d = 1'b1;
            end else begin
              gen_r_d = gen_r_q + CW'(1);
            end
          end else begin
            gen_c_d = gen_c_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_PASS;
      in_idx_q    <= '0;
      gen_r_q     <= '0;
      gen_c_q     <= '0;
      gen_done_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      in_idx_q    <= in_idx_d;
      gen_r_q     <= gen_r_d;
      gen_c_q     <= gen_c_d;
      gen_done_q  <= gen_done_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_resize_stream.sv
// tb_resize_stream: directed checks of resize_stream on a 4x3 frame.
// Covers pass, up, down, backpressure, illegal mode and mid-frame reset.
module tb_resize_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;
  int nrec;
  logic [7:0] got [64];
  logic       lst [64];

  resize_stream #(
    .PIX_W (8),
    .IMG_W (4),
    .IMG_H (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_frame(input bit ff);
    chk("in_ready_load", 32'(in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = ff ? 8'd255 : 8'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit bp);
    int cyc;
    bit hold;
    logic [7:0] hv;
    cyc  = 0;
    hold = 1'b0;
    hv   = '0;
    nrec = 0;
    while (nrec < n && cyc < 400) begin
      out_ready = bp ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(hv));
      end
      hold = out_valid && !out_ready;
      hv   = out_data;
      if (out_valid && out_ready) begin
        got[nrec] = out_data;
        lst[nrec] = out_last;
        nrec++;
      end
      if (nrec < n) begin
        @(posedge clk);
        #1;
      end
      cyc++;
    end
    if (nrec < n) chk("timeout", 32'(nrec), 32'(n));
  endtask

  task automatic check_up(input string tag);
    int r, c;
    for (int i = 0; i < 48; i++) begin
      r = i / 8;
      c = i % 8;
      chk($sformatf("%s_d%0d", tag, i), 32'(got[i]),
          32'((r / 2) * 4 + c / 2));
      chk($sformatf("%s_l%0d", tag, i), 32'(lst[i]),
          32'(i == 47));
    end
  endtask

  task automatic finish_frame;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // pass mode
    kick(2'd0);
    chk("busy_load", 32'(busy), 1);
    load_frame(1'b0);
    chk("proc_entry_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("first_valid", 32'(out_valid), 1);
    collect(12, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("pass_d%0d", i), 32'(got[i]), 32'(i));
      chk($sformatf("pass_l%0d", i), 32'(lst[i]), 32'(i == 11));
    end
    finish_frame();

    // up mode
    kick(2'd1);
    load_frame(1'b0);
    collect(48, 1'b0);
    check_up("up");
    finish_frame();

    // down mode
    kick(2'd2);
    load_frame(1'b0);
    collect(2, 1'b0);
    chk("down_d0", 32'(got[0]), 3);
    chk("down_d1", 32'(got[1]), 5);
    chk("down_l0", 32'(lst[0]), 0);
    chk("down_l1", 32'(lst[1]), 1);
    finish_frame();

    // down mode, saturated inputs
    kick(2'd2);
    load_frame(1'b1);
    collect(2, 1'b0);
    chk("down255_d0", 32'(got[0]), 255);
    chk("down255_d1", 32'(got[1]), 255);
    chk("down255_l1", 32'(lst[1]), 1);
    finish_frame();

    // up mode with alternating backpressure
    kick(2'd1);
    load_frame(1'b0);
    collect(48, 1'b1);
    check_up("bp");
    out_ready = 1'b1;
    finish_frame();

    // illegal mode
    kick(2'd3);
    chk("bad_err", 32'(err), 1);
    chk("bad_in_ready", 32'(in_ready), 0);
    chk("bad_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    chk("bad_err_pulse", 32'(err), 0);
    chk("bad_busy2", 32'(busy), 0);

    // reset mid-frame
    kick(2'd0);
    load_frame(1'b0);
    collect(5, 1'b0);
    chk("pre_rst_d4", 32'(got[4]), 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    kick(2'd0);
    load_frame(1'b0);
    collect(12, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("re_d%0d", i), 32'(got[i]), 32'(i));
      chk($sformatf("re_l%0d", i), 32'(lst[i]), 32'(i == 11));
    end
    finish_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/resize_stream.md
RESIZE_STREAM -- requirements
Module: resize_stream

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel bit width.
REQ-002 The block SHALL have parameter IMG_W, default 410, meaning input image width in pixels.
REQ-003 The block SHALL have parameter IMG_H, default 361, meaning input image height in pixels.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: frame-start request, sampled in IDLE only.
REQ-007 The block SHALL have port mode, input, 2 bits: 0 pass, 1 up 2x, 2 down 2x, 3 illegal; latched on accepted start.
REQ-008 The block SHALL have ports in_data (input, PIX_W), in_valid (input, 1) and in_ready (output, 1): pixel input stream, row-major.
REQ-009 The block SHALL have ports out_data (output, PIX_W), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): pixel output stream, row-major.
REQ-010 The block SHALL have ports busy (output, 1), high outside IDLE, and err (output, 1), a one-cycle illegal-mode pulse.

Function
REQ-011 The block SHALL implement the states IDLE, LOAD, PROC and DONE.
REQ-012 In IDLE, start=1 with mode<3 SHALL latch mode and enter LOAD; start=1 with mode=3 SHALL pulse err for one cycle and remain in IDLE.
REQ-013 In LOAD, in_ready SHALL be 1, and each in_valid&in_ready cycle SHALL write one pixel to buffer index r*IMG_W+c.
REQ-014 Acceptance of pixel IMG_W*IMG_H-1 SHALL move LOAD to PROC on the next edge; in_ready SHALL be 0 in every other state.
REQ-015 Output dimensions SHALL be: pass IMG_W x IMG_H; up 2*IMG_W x 2*IMG_H; down floor(IMG_W/2) x floor(IMG_H/2), dropping an odd last row or column.
REQ-016 In up mode, out(r,c) SHALL equal buf(r/2, c/2) (nearest neighbour).
REQ-017 In down mode, out(r,c) SHALL equal (a+b+d+e+2)>>2 over the 2x2 block at (2r,2c), summed in PIX_W+2 bits with no overflow or saturation.
REQ-018 In pass mode, out(r,c) SHALL equal buf(r,c).
REQ-019 out_valid SHALL rise on the cycle after PROC entry; with out_ready held at 1, throughput SHALL be one pixel per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-021 out_last SHALL be 1 only with the final output pixel; its handshake SHALL enter DONE, and DONE SHALL return to IDLE after one cycle.
REQ-022 start SHALL be ignored while busy=1; in_valid SHALL be ignored outside LOAD.

Reset
REQ-023 While rst=0, the block SHALL force state IDLE, all counters to 0, in_ready/out_valid/out_last/busy/err to 0, and out_data to 0.
REQ-024 Reset asserted mid-LOAD or mid-PROC SHALL abort the frame immediately; buffer contents need not be cleared.

Structure
REQ-025 Shared package resize_pkg SHALL hold the mode encodings, the state enum and the output-dimension constant functions.
REQ-026 Storage SHALL be sub-module resize_fbuf: IMG_W*IMG_H x PIX_W, one write port and four combinational read ports.

Verification (PIX_W=8, IMG_W=4, IMG_H=3, input pixel value = r*4+c)
REQ-027 Pass: the bench SHALL check 12 outputs 0..11, with out_last on value 11 only and busy low 2 cycles after the last handshake.
REQ-028 Up: the bench SHALL check 48 outputs, row 0 = 0,0,1,1,2,2,3,3, row 5 = 8,8,9,9,10,10,11,11, with out_last on output 48.
REQ-029 Down: the bench SHALL check outputs 3 then 5 with out_last on the second; a separate run with all inputs at 255 SHALL output 255, 255.
REQ-030 Backpressure: the bench SHALL run up mode with out_ready=1,0,1,0..., check that out_data is stable across stalls, and check the sequence is identical to REQ-028.
REQ-031 Illegal mode and reset: the bench SHALL check that start with mode=3 gives one err pulse with in_ready=0; rst=0 after 5 down-mode-free pass outputs SHALL clear out_valid and busy within the same cycle; a new pass frame SHALL then produce 0..11.
